axi4lite_slave_regs: RTL
========================

// Module: axi4lite_slave_regs
// PURPOSE
//  Parametrised AXI4-Lite slave that terminates a bus master on a bank of NUM_REGS R/W registers.
//  - Adds response channels (BRESP/RRESP) and out-of-range error reporting.
//  - Accepts the AW and W channels independently; register contents are exported to core logic.
//  - Sits between the AXI4-Lite interconnect/master and design control/status logic.
// PARAMETERS
//  ADDRWIDTH  32  byte-address width of AWADDR/ARADDR
//  DATAWIDTH  32  data bus width; legal values 32 or 64
//  NUM_REGS   16  number of registers, >=1; register i sits at byte address i*(DATAWIDTH/8)
//  RESET_VAL  0   reset value loaded into every register (DATAWIDTH bits)
// PORTS
//  ACLK          in   1                   system clock, all logic on rising edge
//  ARESETN       in   1                   asynchronous active-low reset
//  AWADDR        in   ADDRWIDTH           write address
//  AWVALID       in   1                   write address valid
//  AWREADY       out  1                   write address ready
//  WDATA         in   DATAWIDTH           write data
//  WSTRB         in   DATAWIDTH/8         byte write strobes (AXI4LITE_WSTRB_EN only)
//  WVALID        in   1                   write data valid
//  WREADY        out  1                   write data ready
//  BRESP         out  2                   write response: 2'b00 OKAY, 2'b10 SLVERR
//  BVALID        out  1                   write response valid
//  BREADY        in   1                   write response ready
//  ARADDR        in   ADDRWIDTH           read address
//  ARVALID       in   1                   read address valid
//  ARREADY       out  1                   read address ready
//  RDATA         out  DATAWIDTH           read data
//  RRESP         out  2                   read response: 2'b00 OKAY, 2'b10 SLVERR
//  RVALID        out  1                   read data valid
//  RREADY        in   1                   read data ready
//  reg_out       out  NUM_REGS*DATAWIDTH  flat register contents; reg i at [i*DATAWIDTH +: DATAWIDTH]
//  reg_wr_pulse  out  NUM_REGS            one-cycle pulse on the cycle after register i is written
// BEHAVIOUR
//  Reset (ARESETN low, asynchronous, any time including mid-transaction):
//  - AWREADY, WREADY, ARREADY, BVALID, RVALID, reg_wr_pulse = 0; BRESP, RRESP = 0; RDATA = 0.
//  - All registers = RESET_VAL; AW/W holding buffers cleared; any in-flight transaction is dropped.
//  - READY outputs rise on the first edge after ARESETN deasserts.
//  Decode:
//  - idx = addr >> $clog2(DATAWIDTH/8); low byte-offset bits are ignored.
//  - idx >= NUM_REGS is out of range: writes are discarded with SLVERR; reads return RDATA=0 with SLVERR.
//  Write path:
//  - AWREADY = !aw_held & !BVALID; WREADY = !w_held & !BVALID.
//  - A handshake on either channel without the other loads that channel's holding buffer (aw_held or w_held).
//  - Commit occurs in the cycle where address and data are both available (held or handshaking now) and BVALID=0.
//  - Next edge after commit: register written, BVALID=1 with BRESP, reg_wr_pulse[idx]=1 for one cycle, buffers cleared.
//  - Latency: AW and W in the same cycle -> BVALID on the next cycle.
//  - BVALID/BRESP hold until BREADY; BVALID drops on the edge that completes the B handshake.
//  - New AW/W are accepted from the following cycle; at most one outstanding write.
//  Read path:
//  - ARREADY = !RVALID.
//  - AR handshake: RDATA/RRESP registered and RVALID=1 on the next edge.
//  - RDATA/RRESP stable until RREADY; RVALID clears on the R handshake edge.
//  - Back-to-back reads: at most one read every 2 cycles.
//  Simultaneous events:
//  - Write commit and AR handshake to the same register in the same cycle: read returns the pre-write value.
//  - Read and write channels are otherwise fully independent.
//  - BREADY/RREADY held high continuously is legal.
//  - A VALID deasserted before READY is a master protocol violation; behaviour is unspecified and not checked.
// CONFIGURATION
//  AXI4LITE_WSTRB_EN defined:
//  - WSTRB port present and buffered with WDATA.
//  - Only bytes with WSTRB[b]=1 are updated.
//  - WSTRB=0 still completes with OKAY and pulses reg_wr_pulse.
//  AXI4LITE_WSTRB_EN undefined:
//  - No WSTRB port; every write updates the full word.
// TESTING
//  1 Reset: hold ARESETN=0 5 cycles, release -> all READYs=1 next cycle; read idx0..15 -> RESET_VAL, RRESP=00.
//  2 AW+W same cycle, addr 0x08, data 0xDEADBEEF -> BVALID next cycle, BRESP=00, reg_wr_pulse[2]; read 0x08 = 0xDEADBEEF.
//  3 W 3 cycles before AW (addr 0x0C) with BREADY=0 for 4 cycles -> WREADY=0 after W accepted; BVALID held 4 cycles; no second write accepted.
//  4 Write/read addr 0x40 (idx16, NUM_REGS=16) -> BRESP=10 with registers unchanged; RRESP=10 with RDATA=0.
//  5 Reg 1=0x11111111; write 0x22222222 to 0x04 committing with AR to 0x04 in same cycle -> RDATA=0x11111111; next read 0x22222222.
//  6 WSTRB_EN: reg0=0xAABBCCDD, write 0x11223344 WSTRB=4'b0101 -> reg0=0xAA22CC44; ARESETN pulsed while BVALID=1 -> BVALID=0 immediately.

Source files
------------

// File: rtl/axi4lite_slave_regs.sv
// AXI4-Lite slave terminating a bus master on a bank of NUM_REGS read/write registers.
// AW and W are accepted independently and buffered until both are present; out-of-range
// accesses complete with SLVERR. Register contents are exported flat on reg_out.
// Optional feature macro: AXI4LITE_WSTRB_EN adds the WSTRB port and byte-lane writes;
// without it every write updates the full word.
module axi4lite_slave_regs #(
  parameter int ADDRWIDTH = 32,
  parameter int DATAWIDTH = 32,
  parameter int NUM_REGS  = 16,
  parameter logic [DATAWIDTH-1:0] RESET_VAL = '0
) (
  input  logic                          ACLK,
  input  logic                          ARESETN,
  input  logic [ADDRWIDTH-1:0]          AWADDR,
  input  logic                          AWVALID,
  output logic                          AWREADY,
  input  logic [DATAWIDTH-1:0]          WDATA,
`ifdef AXI4LITE_WSTRB_EN
  input  logic [DATAWIDTH/8-1:0]        WSTRB,
`endif
  input  logic                          WVALID,
  output logic                          WREADY,
  output logic [1:0]                    BRESP,
  output logic                          BVALID,
  input  logic                          BREADY,
  input  logic [ADDRWIDTH-1:0]          ARADDR,
  input  logic                          ARVALID,
  output logic                          ARREADY,
  output logic [DATAWIDTH-1:0]          RDATA,
  output logic [1:0]                    RRESP,
  output logic                          RVALID,
  input  logic                          RREADY,
  output logic [NUM_REGS*DATAWIDTH-1:0] reg_out,
  output logic [NUM_REGS-1:0]           reg_wr_pulse
);

  localparam int STRBW = DATAWIDTH / 8;
  localparam int OFFW  = $clog2(STRBW);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // READYs stay low through reset and rise on the first edge after release.
  logic                 rdy_en;
  logic                 aw_held;
  logic                 w_held;
  logic [ADDRWIDTH-1:0] aw_addr_q;
  logic [DATAWIDTH-1:0] w_data_q;
`ifdef AXI4LITE_WSTRB_EN
  logic [STRBW-1:0]     w_strb_q;
`endif

  logic [DATAWIDTH-1:0] regs [NUM_REGS];

  logic                 aw_hs;
  logic                 w_hs;
  logic                 ar_hs;
  logic                 commit;
  logic [ADDRWIDTH-1:0] wr_addr;
  logic [ADDRWIDTH-1:0] wr_idx;
  logic                 wr_in_range;
  logic [DATAWIDTH-1:0] wr_data;
  logic [STRBW-1:0]     wr_strb;
  logic [ADDRWIDTH-1:0] rd_idx;
  logic                 rd_in_range;
  logic [DATAWIDTH-1:0] rd_word;

  assign AWREADY = rdy_en & ~aw_held & ~BVALID;
  assign WREADY  = rdy_en & ~w_held & ~BVALID;
  assign ARREADY = rdy_en & ~RVALID;

  assign aw_hs = AWVALID & AWREADY;
  assign w_hs  = WVALID & WREADY;
  assign ar_hs = ARVALID & ARREADY;

  // A write commits as soon as address and data are both available, held or arriving now.
  assign commit = (aw_held | aw_hs) & (w_held | w_hs) & ~BVALID;

  assign wr_addr     = aw_held ? aw_addr_q : AWADDR;
  assign wr_data     = w_held ? w_data_q : WDATA;
  assign wr_idx      = wr_addr >> OFFW;
  assign wr_in_range = wr_idx < ADDRWIDTH'(NUM_REGS);
`ifdef AXI4LITE_WSTRB_EN
  assign wr_strb     = w_held ? w_strb_q : WSTRB;
`else
  assign wr_strb     = '1;
`endif

  assign rd_idx      = ARADDR >> OFFW;
  assign rd_in_range = rd_idx < ADDRWIDTH'(NUM_REGS);

  // Read mux; out-of-range indices fall through to zero.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_idx == ADDRWIDTH'(i)) rd_word = regs[i];
    end
  end

  // Flatten the register bank onto the core-facing export bus.
  always_comb begin
    reg_out = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      reg_out[i*DATAWIDTH +: DATAWIDTH] = regs[i];
    end
  end

  // AW/W holding buffers, write response and per-register write pulse.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rdy_en       <= 1'b0;
      aw_held      <= 1'b0;
      w_held       <= 1'b0;
      aw_addr_q    <= '0;
      w_data_q     <= '0;
`ifdef AXI4LITE_WSTRB_EN
      w_strb_q     <= '0;
`endif
      BVALID       <= 1'b0;
      BRESP        <= RESP_OKAY;
      reg_wr_pulse <= '0;
    end else begin
      rdy_en <= 1'b1;
      if (commit) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
        BVALID  <= 1'b1;
        BRESP   <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
      end else begin
        if (aw_hs) begin
          aw_held   <= 1'b1;
          aw_addr_q <= AWADDR;
        end
        if (w_hs) begin
          w_held   <= 1'b1;
          w_data_q <= WDATA;
`ifdef AXI4LITE_WSTRB_EN
          w_strb_q <= WSTRB;
`endif
        end
        if (BVALID && BREADY) BVALID <= 1'b0;
      end
      for (int i = 0; i < NUM_REGS; i++) begin
        reg_wr_pulse[i] <= commit && (wr_idx == ADDRWIDTH'(i));
      end
    end
  end

  // Register bank update; only enabled byte lanes of an in-range target change.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VAL;
    end else if (commit) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_idx == ADDRWIDTH'(i)) begin
          for (int b = 0; b < STRBW; b++) begin
            if (wr_strb[b]) regs[i][b*8 +: 8] <= wr_data[b*8 +: 8];
          end
        end
      end
    end
  end

  // Read channel: capture on AR handshake, hold until the R handshake.
  // Reads sample the bank before any same-edge write lands, so they see the old value.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      RVALID <= 1'b0;
      RDATA  <= '0;
      RRESP  <= RESP_OKAY;
    end else if (ar_hs) begin
      RVALID <= 1'b1;
      RDATA  <= rd_in_range ? rd_word : '0;
      RRESP  <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
    end else if (RVALID && RREADY) begin
      RVALID <= 1'b0;
    end
  end

endmodule
